// File: rtl/layer28_label_trainer.sv
// rtl/layer28_label_trainer.sv - labelled-sample sequencer for the 28-neuron layer
// Fires the layer, scans its outputs for argmax, optionally trains, reports and keeps totals.
module layer28_label_trainer #(
  parameter int unsigned       OUT_W      = 8,
  parameter int unsigned       SETTLE_CYC = 2,
  parameter logic [OUT_W-1:0]  TARGET_HI  = '1,
  parameter logic [OUT_W-1:0]  TARGET_LO  = '0,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4:0]              in_label,
  input  logic                    in_train,
  input  logic [27:0][OUT_W-1:0]  layer_out,
  output logic                    layer_valid,
  output logic                    layer_learn,
  output logic [27:0][OUT_W-1:0]  expected_out,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [4:0]              res_class,
  output logic                    res_correct,
  output logic                    res_bad_label,
  output logic [CNT_W-1:0]        total_cnt,
  output logic [CNT_W-1:0]        correct_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FIRE   = 3'd1,
    SETTLE = 3'd2,
    SCAN   = 3'd3,
    LEARN  = 3'd4,
    REPORT = 3'd5
  } state_t;

  state_t                   state_q, state_d;
  logic [4:0]               label_q, label_d;
  logic                     train_q, train_d;
  logic                     bad_q, bad_d;
  logic [27:0][OUT_W-1:0]   exp_q, exp_d;
  logic [3:0]               settle_q, settle_d;
  logic [4:0]               idx_q, idx_d;
  logic [OUT_W-1:0]         best_q, best_d;
  logic [4:0]               best_idx_q, best_idx_d;
  logic [CNT_W-1:0]         total_q, total_d;
  logic [CNT_W-1:0]         correct_q, correct_d;
  logic [1:0]               rst_sync_q;
  logic                     rst_n_int;
  logic                     correct_now;

  // Reset asserts asynchronously but releases two clocks later, in step with clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign rst_n_int = rst_sync_q[1];

  assign correct_now = !bad_q && (best_idx_q == label_q);

  always_comb begin
    state_d    = state_q;
    label_d    = label_q;
    train_d    = train_q;
    bad_d      = bad_q;
    exp_d      = exp_q;
    settle_d   = settle_q;
    idx_d      = idx_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    total_d    = total_q;
    correct_d  = correct_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          label_d = in_label;
          train_d = in_train;
          bad_d   = (in_label > 5'd27);
          for (int i = 0; i < 28; i++) begin
            exp_d[i] = ((in_label <= 5'd27) && (in_label == 5'(i))) ? TARGET_HI : TARGET_LO;
          end
          state_d = FIRE;
        end
      end
      FIRE: begin
        settle_d = 4'(SETTLE_CYC);
        state_d  = SETTLE;
      end
      SETTLE: begin
        settle_d = settle_q - 4'd1;
        if (settle_q <= 4'd1) begin
          best_d     = layer_out[0];
          best_idx_d = 5'd0;
          idx_d      = 5'd1;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        // Strict compare so equal values keep the lower index.
        if (layer_out[idx_q] > best_q) begin
          best_d     = layer_out[idx_q];
          best_idx_d = idx_q;
        end
        idx_d = idx_q + 5'd1;
        if (idx_q == 5'd27) begin
          state_d = (train_q && !bad_q) ? LEARN : REPORT;
        end
      end
      LEARN: begin
        state_d = REPORT;
      end
      REPORT: begin
        if (res_ready) begin
          if (total_q != {CNT_W{1'b1}}) begin
            total_d = total_q + 1'b1;
          end
          if (correct_now && (correct_q != {CNT_W{1'b1}})) begin
            correct_d = correct_q + 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q    <= IDLE;
      label_q    <= 5'd0;
      train_q    <= 1'b0;
      bad_q      <= 1'b0;
      exp_q      <= '0;
      settle_q   <= 4'd0;
      idx_q      <= 5'd0;
      best_q     <= '0;
      best_idx_q <= 5'd0;
      total_q    <= '0;
      correct_q  <= '0;
    end else begin
      state_q    <= state_d;
      label_q    <= label_d;
      train_q    <= train_d;
      bad_q      <= bad_d;
      exp_q      <= exp_d;
      settle_q   <= settle_d;
      idx_q      <= idx_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      total_q    <= total_d;
      correct_q  <= correct_d;
    end
  end

  // Strobes decode straight from state so a reset drops them without waiting for a clock.
  assign in_ready      = (state_q == IDLE);
  assign layer_valid   = (state_q == FIRE) || (state_q == LEARN);
  assign layer_learn   = (state_q == LEARN);
  assign res_valid     = (state_q == REPORT);
  assign res_class     = best_idx_q;
  assign res_correct   = res_valid && correct_now;
  assign res_bad_label = res_valid && bad_q;
  assign expected_out  = exp_q;
  assign total_cnt     = total_q;
  assign correct_cnt   = correct_q;

endmodule

// File: tb/tb_layer28_label_trainer.sv
// tb/tb_layer28_label_trainer.sv - directed scoreboard bench for layer28_label_trainer
module tb_layer28_label_trainer;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              in_valid, in_train, res_ready;
  logic [4:0]        in_label;
  logic [27:0][7:0]  lo;
  logic              in_ready, layer_valid, layer_learn, res_valid, res_correct, res_bad_label;
  logic [27:0][7:0]  expected_out;
  logic [4:0]        res_class;
  logic [15:0]       total_cnt, correct_cnt;

  logic              s_in_valid, s_res_ready;
  logic              s_in_ready, s_layer_valid, s_layer_learn, s_res_valid, s_res_correct, s_res_bad;
  logic [27:0][7:0]  s_expected_out;
  logic [4:0]        s_res_class;
  logic [3:0]        s_total, s_correct;

  typedef struct {
    logic [4:0] cls;
    logic       cor;
    logic       bad;
  } res_t;

  res_t        sb[$];
  int          n_total = 0;
  int          n_bad   = 0;
  logic [15:0] tot_m, cor_m;

  always #5 clock = ~clock;

  layer28_label_trainer u_dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_label(in_label), .in_train(in_train), .layer_out(lo), .layer_valid(layer_valid),
    .layer_learn(layer_learn), .expected_out(expected_out), .res_valid(res_valid),
    .res_ready(res_ready), .res_class(res_class), .res_correct(res_correct),
    .res_bad_label(res_bad_label), .total_cnt(total_cnt), .correct_cnt(correct_cnt)
  );

  layer28_label_trainer #(.CNT_W(4)) u_sat (
    .clock(clock), .reset_n(reset_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_label(in_label), .in_train(in_train), .layer_out(lo), .layer_valid(s_layer_valid),
    .layer_learn(s_layer_learn), .expected_out(s_expected_out), .res_valid(s_res_valid),
    .res_ready(s_res_ready), .res_class(s_res_class), .res_correct(s_res_correct),
    .res_bad_label(s_res_bad), .total_cnt(s_total), .correct_cnt(s_correct)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [4:0] argmax(input logic [27:0][7:0] v);
    logic [7:0] b;
    logic [4:0] k;
    b = v[0];
    k = 5'd0;
    for (int i = 1; i < 28; i++) begin
      if (v[i] > b) begin
        b = v[i];
        k = 5'(i);
      end
    end
    return k;
  endfunction

  function automatic logic [27:0][7:0] exp_vec(input logic [4:0] lab);
    logic [27:0][7:0] v;
    v = '0;
    for (int i = 0; i < 28; i++) begin
      if (int'(lab) == i) v[i] = 8'hFF;
    end
    return v;
  endfunction

  task automatic set_lo(input logic [7:0] base, input int a, input logic [7:0] av,
                        input int b, input logic [7:0] bv);
    for (int i = 0; i < 28; i++) lo[i] = base;
    lo[a] = av;
    lo[b] = bv;
  endtask

  task automatic run_sample(input string nm, input logic [4:0] lab, input logic tr, input int hold);
    res_t e;
    int   cyc, fires, learns, fire_cyc, learn_cyc, lat;
    logic want_learn;
    e.bad      = (lab > 5'd27);
    e.cls      = argmax(lo);
    e.cor      = !e.bad && (e.cls == lab);
    sb.push_back(e);
    want_learn = tr && !e.bad;
    lat        = want_learn ? 32 : 31;
    in_label   = lab;
    in_train   = tr;
    in_valid   = 1'b1;
    chk({nm, "_in_ready"}, in_ready, 1'b1);
    tick();
    in_valid  = 1'b0;
    cyc       = 1;
    fires     = 0;
    learns    = 0;
    fire_cyc  = -1;
    learn_cyc = -1;
    chk({nm, "_expected_out"}, expected_out, exp_vec(lab));
    while (!res_valid && cyc < 80) begin
      if (layer_valid) begin
        fires++;
        if (fire_cyc < 0) fire_cyc = cyc;
      end
      if (layer_learn) begin
        learns++;
        learn_cyc = cyc;
      end
      tick();
      cyc++;
    end
    chk({nm, "_latency"}, cyc, lat);
    chk({nm, "_fire_cyc"}, fire_cyc, 1);
    chk({nm, "_valid_pulses"}, fires, want_learn ? 2 : 1);
    chk({nm, "_learn_pulses"}, learns, want_learn ? 1 : 0);
    chk({nm, "_learn_cyc"}, learn_cyc, want_learn ? 31 : -1);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      chk({nm, "_hold_valid"}, {res_valid, in_ready}, 2'b10);
      chk({nm, "_hold_fields"}, {res_class, res_correct, res_bad_label}, {sb[0].cls, sb[0].cor, sb[0].bad});
      tick();
    end
    in_valid  = 1'b0;
    e         = sb.pop_front();
    chk({nm, "_res_valid"}, res_valid, 1'b1);
    chk({nm, "_res_class"}, res_class, e.cls);
    chk({nm, "_res_correct"}, res_correct, e.cor);
    chk({nm, "_res_bad"}, res_bad_label, e.bad);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    if (tot_m != 16'hFFFF) tot_m++;
    if (e.cor && cor_m != 16'hFFFF) cor_m++;
    chk({nm, "_after_idle"}, {res_valid, in_ready}, 2'b01);
    chk({nm, "_total_cnt"}, total_cnt, tot_m);
    chk({nm, "_correct_cnt"}, correct_cnt, cor_m);
  endtask

  initial begin
    int         w;
    logic [3:0] sat_m;
    reset_n     = 1'b0;
    in_valid    = 1'b0;
    in_train    = 1'b0;
    in_label    = 5'd0;
    res_ready   = 1'b0;
    s_in_valid  = 1'b0;
    s_res_ready = 1'b0;
    lo          = '0;
    tot_m       = '0;
    cor_m       = '0;
    tick();
    tick();
    chk("reset_ready", in_ready, 1'b1);
    chk("reset_strobes", {layer_valid, layer_learn, res_valid}, 3'b000);
    chk("reset_res", {res_class, res_correct, res_bad_label}, 7'd0);
    chk("reset_expected", expected_out, 224'd0);
    chk("reset_counts", {total_cnt, correct_cnt}, 32'd0);
    #2 reset_n = 1'b1;
    repeat (4) tick();

    set_lo(8'h10, 5, 8'hF0, 5, 8'hF0);
    run_sample("s1", 5'd5, 1'b0, 0);
    set_lo(8'h20, 9, 8'hC0, 9, 8'hC0);
    run_sample("s2", 5'd3, 1'b1, 0);
    set_lo(8'h30, 4, 8'hFF, 20, 8'hFF);
    run_sample("tie", 5'd20, 1'b0, 0);
    set_lo(8'h40, 12, 8'h90, 12, 8'h90);
    run_sample("badlbl", 5'd30, 1'b1, 0);
    set_lo(8'h05, 7, 8'h77, 7, 8'h77);
    run_sample("hold", 5'd7, 1'b1, 10);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 28; i++) lo[i] = 8'($urandom_range(0, 255));
      run_sample("rand", 5'($urandom_range(0, 27)), 1'b1, 1);
    end

    set_lo(8'h10, 5, 8'hF0, 5, 8'hF0);
    in_label = 5'd5;
    in_train = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (12) tick();
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_strobes", {layer_valid, layer_learn, res_valid}, 3'b000);
    chk("midrst_ready", in_ready, 1'b1);
    chk("midrst_counts", {total_cnt, correct_cnt}, 32'd0);
    chk("midrst_expected", expected_out, 224'd0);
    tick();
    #2 reset_n = 1'b1;
    repeat (4) tick();
    tot_m = '0;
    cor_m = '0;
    run_sample("post_rst", 5'd5, 1'b0, 0);

    sat_m = 4'd0;
    in_label = 5'd5;
    in_train = 1'b0;
    for (int k = 0; k < 17; k++) begin
      s_in_valid = 1'b1;
      tick();
      s_in_valid = 1'b0;
      w = 0;
      while (!s_res_valid && w < 80) begin
        tick();
        w++;
      end
      chk("sat_wait", s_res_valid, 1'b1);
      s_res_ready = 1'b1;
      tick();
      s_res_ready = 1'b0;
      if (sat_m != 4'hF) sat_m++;
      chk("sat_total", s_total, sat_m);
      chk("sat_correct", s_correct, sat_m);
    end
    chk("sat_final", {s_total, s_correct}, 8'hFF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
